// File: rtl/i2s_tx_stereo_if.sv
// Sample-pair handshake and I2S line bundle for the stereo transmitter.
// The source side uses master; the transmitter uses slave.
interface i2s_tx_stereo_if #(
  parameter int BITS_PRECISION = 10
);
  logic [BITS_PRECISION-1:0] in_left;
  logic [BITS_PRECISION-1:0] in_right;
  logic                      in_valid;
  logic                      in_ready;
  logic                      ws;
  logic                      sd;
  logic                      frame_start;
  logic                      underrun;

  modport master (
    output in_left, in_right, in_valid,
    input  in_ready, ws, sd, frame_start, underrun
  );

  modport slave (
    input  in_left, in_right, in_valid,
    output in_ready, ws, sd, frame_start, underrun
  );
endinterface

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S transmitter. One left/right pair per frame, one frame of
// buffering, MSB-first with the one-bit delay after every ws edge.
// Everything runs on sck; all line outputs are registered.
module i2s_tx_stereo #(
  parameter int BITS_PRECISION = 10,
  parameter int SLOT_BITS      = 16
) (
  input  logic            sck,
  input  logic            rst,
  i2s_tx_stereo_if.slave  bus
);

  localparam int              PW     = $clog2(SLOT_BITS);
  localparam logic [PW-1:0]   P_LAST = PW'(SLOT_BITS - 1);
  localparam logic [PW-1:0]   P_ONE  = PW'(1);
  localparam logic [PW-1:0]   P_BITS = PW'(BITS_PRECISION);

  // A slot must fit the delay bit plus every data bit.
  generate
    if (SLOT_BITS < BITS_PRECISION + 1) begin : g_bad_slot
      $error("i2s_tx_stereo: SLOT_BITS must be >= BITS_PRECISION+1");
    end
  endgenerate

  logic [PW-1:0]             p_q, p_d;
  logic                      ws_q, ws_d;
  logic [BITS_PRECISION-1:0] hold_l_q, hold_l_d;
  logic [BITS_PRECISION-1:0] hold_r_q, hold_r_d;
  logic                      hold_full_q, hold_full_d;
  logic [BITS_PRECISION-1:0] act_l_q, act_l_d;
  logic [BITS_PRECISION-1:0] act_r_q, act_r_d;
  logic                      primed_q, primed_d;
  logic                      sd_q, sd_d;
  logic                      frame_start_q, frame_start_d;
  logic                      underrun_q, underrun_d;

  logic                      load;
  logic                      in_ready;
  logic                      xfer;
  logic [BITS_PRECISION-1:0] word;
  logic [BITS_PRECISION-1:0] word_sh;
  logic [PW-1:0]             shamt;

  // Last cycle of the right slot: the active words are replaced here.
  assign load     = (p_q == P_LAST) && ws_q;
  // In reset the holding register is being emptied, so report ready.
  assign in_ready = !rst || !hold_full_q || load;
  assign xfer     = bus.in_valid && in_ready;

  // Next-state: slot counter, buffer movement, and the registered line values.
  always_comb begin
    p_d           = (p_q == P_LAST) ? '0 : p_q + P_ONE;
    ws_d          = (p_q == P_LAST) ? ~ws_q : ws_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    hold_full_d   = hold_full_q;
    act_l_d       = act_l_q;
    act_r_d       = act_r_q;
    primed_d      = primed_q;
    word          = '0;
    word_sh       = '0;
    shamt         = '0;
    sd_d          = 1'b0;

    if (load) begin
      if (hold_full_q) begin
        act_l_d     = hold_l_q;
        act_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        act_l_d     = '0;
        act_r_d     = '0;
      end
    end

    // A pair arriving on an empty load cycle waits a frame; it never bypasses
    // into the active words, so a frame is never half old and half new.
    if (xfer) begin
      hold_l_d    = bus.in_left;
      hold_r_d    = bus.in_right;
      hold_full_d = 1'b1;
      primed_d    = 1'b1;
    end

    frame_start_d = load;
    underrun_d    = load && !hold_full_q && primed_q;

    // Data bit for the position shown next cycle: p=1 carries the MSB.
    word  = ws_d ? act_r_d : act_l_d;
    shamt = p_d - P_ONE;
    word_sh = word << shamt;
    if ((p_d != '0) && (p_d <= P_BITS)) begin
      sd_d = word_sh[BITS_PRECISION-1];
    end
  end

  // State register; reset parks the counter on the load cycle.
  always_ff @(posedge sck) begin
    if (!rst) begin
      p_q           <= P_LAST;
      ws_q          <= 1'b1;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      act_l_q       <= '0;
      act_r_q       <= '0;
      primed_q      <= 1'b0;
      sd_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      p_q           <= p_d;
      ws_q          <= ws_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      act_l_q       <= act_l_d;
      act_r_q       <= act_r_d;
      primed_q      <= primed_d;
      sd_q          <= sd_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ws          = ws_q;
  assign bus.sd          = sd_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Bench for i2s_tx_stereo: a frame-level model (pending pair, current frame
// words, cycle index since reset) checked every cycle, plus literal checks.
module tb_i2s_tx_stereo;
  localparam int B = 10;
  localparam int S = 16;
  localparam int F = 2 * S;

  logic sck = 1'b0;
  logic rst = 1'b0;

  i2s_tx_stereo_if #(.BITS_PRECISION(B)) bus ();

  i2s_tx_stereo #(.BITS_PRECISION(B), .SLOT_BITS(S)) dut (
    .sck (sck),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 sck = ~sck;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int         t = 0;
  bit         model_on = 0;
  bit         pend = 0;
  bit         primed_m = 0;
  bit         ur_flag = 0;
  logic [B-1:0] pend_l = '0, pend_r = '0;
  logic [B-1:0] cur_l = '0, cur_r = '0;
  int         acc_log [0:15];
  int         n_acc = 0;

  logic sd_log [0:511];
  logic ws_log [0:511];
  logic fs_log [0:511];
  logic ur_log [0:511];
  logic rdy_log[0:511];

  task automatic chk(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got %b want %b", name, t, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    pend     = 0;
    primed_m = 0;
    ur_flag  = 0;
    cur_l    = '0;
    cur_r    = '0;
    n_acc    = 0;
  endtask

  // Model + compare: outputs in cycle t follow from the frame position.
  always @(negedge sck) begin
    int k, pp;
    bit e_ws, e_sd, e_fs, e_ur, e_rdy, load_m;
    logic [B-1:0] w;
    if (!model_on) begin
      if (!rst) begin
        model_reset();
        model_on = 1;
      end
    end else begin
      k      = (t + F - 1) % F;
      e_ws   = (k >= S);
      pp     = k % S;
      w      = e_ws ? cur_r : cur_l;
      e_sd   = (pp >= 1 && pp <= B) ? w[B-pp] : 1'b0;
      e_fs   = (k == 0);
      e_ur   = (k == 0) && ur_flag;
      load_m = (k == F - 1);
      e_rdy  = !rst || !pend || load_m;

      chk("ws", bus.ws, e_ws);
      chk("sd", bus.sd, e_sd);
      chk("frame_start", bus.frame_start, e_fs);
      chk("underrun", bus.underrun, e_ur);
      chk("in_ready", bus.in_ready, e_rdy);

      if (t < 512) begin
        sd_log[t]  = bus.sd;
        ws_log[t]  = bus.ws;
        fs_log[t]  = bus.frame_start;
        ur_log[t]  = bus.underrun;
        rdy_log[t] = bus.in_ready;
      end

      if (!rst) begin
        model_reset();
      end else begin
        if (load_m) begin
          if (pend) begin
            cur_l   = pend_l;
            cur_r   = pend_r;
            pend    = 0;
            ur_flag = 0;
          end else begin
            cur_l   = '0;
            cur_r   = '0;
            ur_flag = primed_m;
          end
        end
        if (bus.in_valid && e_rdy) begin
          pend     = 1;
          pend_l   = bus.in_left;
          pend_r   = bus.in_right;
          primed_m = 1;
          if (n_acc < 16) acc_log[n_acc] = t;
          n_acc++;
        end
        t++;
      end
    end
  end

  // Caller sits just after a posedge; leaves cycle 0 after release current.
  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge sck);
    #1 rst = 1'b1;
  endtask

  task automatic wait_t(input int n);
    int guard = 0;
    while (t < n && guard < 2000) begin
      @(posedge sck);
      #1;
      guard++;
    end
    if (t < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_t got %0d want %0d", t, n);
    end
  endtask

  task automatic send(input logic [B-1:0] l, input logic [B-1:0] r);
    bit got = 0;
    bus.in_left  = l;
    bus.in_right = r;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge sck);
      got = bus.in_ready;
      @(posedge sck);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout got 0 want 1");
    end
  endtask

  logic [B-1:0] lit_l, lit_r;
  logic any;

  initial begin
    bus.in_left  = '0;
    bus.in_right = '0;
    bus.in_valid = 1'b0;

    // 1: idle after reset
    do_reset(3);
    wait_t(100);
    chk("idle_ws0", ws_log[0], 1'b1);
    chk("idle_ws1", ws_log[1], 1'b0);
    chk("idle_ws17", ws_log[17], 1'b1);
    chk("idle_fs1", fs_log[1], 1'b1);
    chk("idle_fs33", fs_log[33], 1'b1);
    chk("idle_fs65", fs_log[65], 1'b1);
    chk("idle_fs32", fs_log[32], 1'b0);
    any = 1'b0;
    for (int i = 0; i < 100; i++) any = any | sd_log[i] | ur_log[i];
    chk("idle_quiet", any, 1'b0);

    // 2: pattern 0x2AB/0x155, offered on the first load cycle
    do_reset(2);
    send(10'h2AB, 10'h155);
    wait_t(70);
    lit_l = 10'b1010101011;
    lit_r = 10'b0101010101;
    for (int i = 0; i < B; i++) begin
      chk("pat_left", sd_log[34 + i], lit_l[B-1-i]);
      chk("pat_right", sd_log[50 + i], lit_r[B-1-i]);
    end
    chk("pat_delay", sd_log[33], 1'b0);
    any = 1'b0;
    for (int i = 44; i < 50; i++) any = any | sd_log[i];
    chk("pat_pad", any, 1'b0);
    chk("pat_no_ur", ur_log[33], 1'b0);

    // 3: back-to-back source, then underrun, then load-cycle offer
    do_reset(2);
    send(10'd1, 10'd2);
    send(10'd3, 10'd4);
    send(10'd5, 10'd6);
    wait_t(140);
    send(10'd7, 10'd8);
    wait_t(192);
    send(10'd9, 10'd10);
    wait_t(270);
    chk_int("acc0", acc_log[0], 0);
    chk_int("acc1", acc_log[1], 32);
    chk_int("acc2", acc_log[2], 64);
    chk_int("acc3", acc_log[3], 140);
    chk_int("acc4", acc_log[4], 192);
    chk("b2b_L1", sd_log[43], 1'b1);
    chk("b2b_L1_b1", sd_log[42], 1'b0);
    chk("b2b_R2", sd_log[58], 1'b1);
    chk("b2b_R2_b0", sd_log[59], 1'b0);
    chk("b2b_L3", sd_log[74], 1'b1);
    chk("b2b_L5", sd_log[107], 1'b1);
    chk("b2b_no_ur", ur_log[33] | ur_log[65] | ur_log[97], 1'b0);
    chk("ur_pulse", ur_log[129], 1'b1);
    chk("ur_fs", fs_log[129], 1'b1);
    any = 1'b0;
    for (int i = 129; i < 161; i++) any = any | sd_log[i];
    chk("ur_frame_zero", any, 1'b0);
    chk("ur_once", ur_log[161], 1'b0);
    chk("L7_b0", sd_log[171], 1'b1);
    chk("L7_b3", sd_log[168], 1'b0);
    chk("R8_b3", sd_log[184], 1'b1);
    chk("ld_ur", ur_log[193], 1'b1);
    any = 1'b0;
    for (int i = 193; i < 225; i++) any = any | sd_log[i];
    chk("ld_frame_zero", any, 1'b0);
    chk("L9_b3", sd_log[232], 1'b1);
    chk("L9_b2", sd_log[233], 1'b0);
    chk("L9_b0", sd_log[235], 1'b1);
    chk("R10_b3", sd_log[248], 1'b1);
    chk("R10_b1", sd_log[250], 1'b1);
    chk("R10_b0", sd_log[251], 1'b0);

    // 4: reset at p=5 of a right slot with holding full
    do_reset(2);
    send(10'h3FF, 10'h3FF);
    wait_t(33);
    send(10'h2AA, 10'h155);
    wait_t(54);
    chk("pre_rst_data", sd_log[34], 1'b1);
    do_reset(2);
    wait_t(80);
    chk("post_rst_rdy", rdy_log[0], 1'b1);
    chk("post_rst_ws1", ws_log[1], 1'b0);
    chk("post_rst_fs1", fs_log[1], 1'b1);
    any = 1'b0;
    for (int i = 0; i < 80; i++) any = any | sd_log[i] | ur_log[i];
    chk("post_rst_quiet", any, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/i2s_tx_stereo.md
Name: i2s_tx_stereo

Overview:
- Stereo I2S transmitter; upstream counterpart of the single-channel I2S receiver stage.
- Accepts one left/right sample pair per frame over a valid/ready handshake and buffers one pending frame.
- Generates the word-select line and serial data, MSB-first, with the standard one-bit I2S delay after each word-select transition.
- Single sck domain: all outputs change on the sck posedge. Used as the mixer's output serializer and as a loopback source for receiver benches.

Parameters:
- BITS_PRECISION, 10, sample width in bits per channel.
- SLOT_BITS, 16, sck cycles per channel slot. Must be >= BITS_PRECISION+1; elaboration error otherwise.

Ports:
- sck  input  1  bit clock; the only clock.
- rst  input  1  synchronous, active-low reset (sampled on sck posedge, active when 0).
- in_left  input  BITS_PRECISION  left sample, two's complement.
- in_right  input  BITS_PRECISION  right sample.
- in_valid  input  1  sample pair presented.
- in_ready  output  1  holding register can accept a pair this cycle.
- ws  output  1  word select; 0 = left slot, 1 = right slot.
- sd  output  1  serial data.
- frame_start  output  1  one-cycle pulse on the first cycle of each left slot.
- underrun  output  1  one-cycle pulse when a frame starts with no pending data (after priming).

Behaviour:
- Registers:
  - p: slot position counter, 0..SLOT_BITS-1.
  - ws.
  - hold_l, hold_r, hold_full: one-frame holding buffer.
  - act_l, act_r: active frame words.
  - primed.
  - sd, frame_start, underrun: all registered.
- Reset (rst=0 at a posedge):
  - p=SLOT_BITS-1, ws=1.
  - hold_full=0, primed=0.
  - act_l=act_r=0, sd=0, frame_start=0, underrun=0.
  - in_ready reads 1 during and after reset.
  - The first cycle after reset release is therefore a load cycle.
- Counter:
  - p increments every cycle.
  - At p=SLOT_BITS-1, p wraps to 0 and ws toggles.
  - Frame period is 2*SLOT_BITS cycles.
- Load cycle (p=SLOT_BITS-1 and ws=1, i.e. the last cycle of the right slot):
  - If hold_full: act_l/act_r <= hold_l/hold_r, and hold_full clears unless refilled this same cycle.
  - If not hold_full: act_l/act_r <= 0, and underrun pulses in the next cycle when primed=1.
- frame_start is high exactly in the cycles where ws=0 and p=0.
- Serial data, in the cycle where the outputs show (ws, p):
  - p=0: sd=0 (I2S one-bit delay slot).
  - 1 <= p <= BITS_PRECISION: sd = bit (BITS_PRECISION-p) of act_l when ws=0, or of act_r when ws=1. MSB first.
  - p > BITS_PRECISION: sd=0 (padding).
- Handshake:
  - in_ready = !hold_full OR load cycle (flow-through on the load cycle).
  - Transfer occurs when in_valid && in_ready: hold_l/hold_r capture the inputs, hold_full=1, primed=1.
  - Transfer on a load cycle with hold_full=1: the old contents move to active and the new pair enters holding in the same cycle. No loss, no duplication.
  - Transfer on a load cycle with hold_full=0: no bypass to active. The frame is sent as zeros, the pair is held for the next frame, and underrun pulses only if primed was already 1 before this cycle.
- Inputs are held by the source until accepted. Changing in_left/in_right while in_valid=1 and in_ready=0 is a protocol violation; behaviour is undefined.
- The active words never change outside a load cycle. A right-slot word always belongs to the same pair as the preceding left-slot word.
- Reset asserted mid-frame: the next cycle after release restarts at the reset state. Pending and active data are discarded, and no partial word is completed.
- Latency: a pair accepted while the block is idle appears at the next load cycle, with its MSB on sd 2 cycles after the load (p=1 of the left slot).

Test Plan:
- Reset then idle, in_valid=0 for 3 frames -> ws toggles every 16 cycles starting at 0 in cycle 1 after release; frame_start at cycles 1, 33, 65; sd constant 0; underrun never pulses (unprimed).
- Accept left=0x2AB, right=0x155 before the first load -> left slot p=1..10 sd = 1,0,1,0,1,0,1,0,1,1; right slot p=1..10 sd = 0,1,0,1,0,1,0,1,0,1; sd=0 at p=0 and p=11..15.
- Back-to-back source with in_valid always 1, pairs (1,2),(3,4),(5,6) -> one pair accepted per frame on the load cycle after holding fills; serial order L1,R2,L3,R4,L5,R6; no underrun.
- After priming, withhold data for one frame -> underrun pulses once, coincident with frame_start; that frame transmits all zeros; the next supplied pair is transmitted in the following frame.
- Pair offered exactly on a load cycle with holding empty -> accepted, current frame is zeros with underrun=1 (primed), and the pair goes out in the next frame.
- Reset asserted at p=5 of a right slot with holding full -> after release, ws=0, p=0, sd=0, in_ready=1; the held pair is never transmitted.
